// File: rtl/alu_secuencial_pkg.sv
// Shared opcode values, FSM state encoding and iterator mode select
// used by the sequential ALU and its multiply/divide iterator.
package alu_secuencial_pkg;

  // Opcode values. Anything not listed here is an illegal opcode.
  localparam logic [4:0] OP_NOT = 5'h00;
  localparam logic [4:0] OP_AND = 5'h01;
  localparam logic [4:0] OP_OR  = 5'h02;
  localparam logic [4:0] OP_NEG = 5'h03;
  localparam logic [4:0] OP_ADD = 5'h04;
  localparam logic [4:0] OP_SUB = 5'h05;
  localparam logic [4:0] OP_MUL = 5'h06;
  localparam logic [4:0] OP_DIV = 5'h07;
  localparam logic [4:0] OP_REM = 5'h08;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Iterator mode select.
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider.
// One bit per clock, BITS_DATA steps. The hi/lo register pair is shared:
//   multiply: hi = partial product high half, lo = multiplier shifting out
//             (and product low half shifting in)
//   divide:   hi = partial remainder, lo = dividend shifting out
//             (and quotient bits shifting in)
// done is high during the final step; the result ports show the value the
// registers take at that edge, so the caller can capture the finished
// result on the same edge the iterator goes idle.
module alu_muldiv_iter
  import alu_secuencial_pkg::*;
#(
  parameter int BITS_DATA = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [BITS_DATA-1:0] a,
  input  logic [BITS_DATA-1:0] b,
  output logic                 done,
  output logic [BITS_DATA-1:0] product_lo,
  output logic [BITS_DATA-1:0] product_hi,
  output logic [BITS_DATA-1:0] quotient,
  output logic [BITS_DATA-1:0] remainder
);

  localparam int CW = $clog2(BITS_DATA);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS_DATA - 1);

  logic                 busy;
  logic                 mode_q;
  logic [CW-1:0]        cnt;
  logic [BITS_DATA-1:0] opnd;
  logic [BITS_DATA-1:0] hi;
  logic [BITS_DATA-1:0] lo;

  logic [BITS_DATA:0]   mul_sum;
  logic [BITS_DATA:0]   div_t;
  logic                 div_ge;
  logic [BITS_DATA-1:0] hi_nxt;
  logic [BITS_DATA-1:0] lo_nxt;

  // One iteration step of the selected algorithm.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_t   = {hi, lo[BITS_DATA-1]};
    div_ge  = (div_t >= {1'b0, opnd});
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (mode_q == MODE_MUL) begin
      hi_nxt = mul_sum[BITS_DATA:1];
      lo_nxt = {mul_sum[0], lo[BITS_DATA-1:1]};
    end else begin
      hi_nxt = div_ge ? (div_t[BITS_DATA-1:0] - opnd) : div_t[BITS_DATA-1:0];
      lo_nxt = {lo[BITS_DATA-2:0], div_ge};
    end
  end

  assign done       = busy && (cnt == CNT_LAST);
  assign product_lo = lo_nxt;
  assign product_hi = hi_nxt;
  assign quotient   = lo_nxt;
  assign remainder  = hi_nxt;

  // Load operands on start, then step until the terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      mode_q <= MODE_MUL;
      cnt    <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_q <= mode;
      cnt    <= '0;
      opnd   <= (mode == MODE_DIV) ? b : a;
      hi     <= '0;
      lo     <= (mode == MODE_DIV) ? a : b;
    end else if (busy) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      if (cnt == CNT_LAST) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_secuencial.sv
// Multi-cycle ALU with registered result and flags.
// Handshake: an operation transfers on a rising edge where in_valid and
// in_ready are both 1 (in_ready is 1 only in IDLE); a result transfers on
// an edge where out_valid and out_ready are both 1. In DONE the result and
// flags stay stable until that transfer; the block then spends one cycle in
// IDLE before it can accept again.
module alu_secuencial
  import alu_secuencial_pkg::*;
#(
  parameter int BITS_DATA   = 32,
  parameter int BITS_OPCODE = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITS_DATA-1:0]   operando_a,
  input  logic [BITS_DATA-1:0]   operando_b,
  input  logic [BITS_OPCODE-1:0] opcode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS_DATA-1:0]   resultado,
  output logic                   C,
  output logic                   S,
  output logic                   O,
  output logic                   Z,
  output logic                   err,
  output state_t                 fsm_state
);

  localparam int M = BITS_DATA - 1;

  localparam logic [BITS_OPCODE-1:0] C_NOT = BITS_OPCODE'(OP_NOT);
  localparam logic [BITS_OPCODE-1:0] C_AND = BITS_OPCODE'(OP_AND);
  localparam logic [BITS_OPCODE-1:0] C_OR  = BITS_OPCODE'(OP_OR);
  localparam logic [BITS_OPCODE-1:0] C_NEG = BITS_OPCODE'(OP_NEG);
  localparam logic [BITS_OPCODE-1:0] C_ADD = BITS_OPCODE'(OP_ADD);
  localparam logic [BITS_OPCODE-1:0] C_SUB = BITS_OPCODE'(OP_SUB);
  localparam logic [BITS_OPCODE-1:0] C_MUL = BITS_OPCODE'(OP_MUL);
  localparam logic [BITS_OPCODE-1:0] C_DIV = BITS_OPCODE'(OP_DIV);
  localparam logic [BITS_OPCODE-1:0] C_REM = BITS_OPCODE'(OP_REM);

  state_t state_q, state_d;
  logic [BITS_OPCODE-1:0] op_q;

  logic                 accept;
  logic                 start;
  logic                 go_mul;
  logic                 go_div;

  // Single-cycle / early-exit result computed straight from the inputs.
  logic [BITS_DATA-1:0] fast_res;
  logic [BITS_DATA:0]   sum;
  logic                 fast_c;
  logic                 fast_o;
  logic                 fast_err;
  logic                 fast_legal;
  logic                 fast_s;
  logic                 fast_z;

  // Iterator interface.
  logic                 iter_done;
  logic [BITS_DATA-1:0] product_lo;
  logic [BITS_DATA-1:0] product_hi;
  logic [BITS_DATA-1:0] quotient;
  logic [BITS_DATA-1:0] remainder;
  logic [BITS_DATA-1:0] iter_res;
  logic                 iter_o;
  logic                 iter_finish;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign fsm_state = state_q;
  assign accept    = in_valid && in_ready;
  assign start     = accept && (go_mul || go_div);

  // Decode the incoming opcode and evaluate everything that needs no iteration.
  always_comb begin
    fast_res   = '0;
    sum        = '0;
    fast_c     = 1'b0;
    fast_o     = 1'b0;
    fast_err   = 1'b0;
    fast_legal = 1'b1;
    go_mul     = 1'b0;
    go_div     = 1'b0;
    case (opcode)
      C_NOT: fast_res = ~operando_a;
      C_AND: fast_res = operando_a & operando_b;
      C_OR:  fast_res = operando_a | operando_b;
      C_NEG: fast_res = '0 - operando_a;
      C_ADD: begin
        sum      = {1'b0, operando_a} + {1'b0, operando_b};
        fast_res = sum[M:0];
        fast_c   = sum[BITS_DATA];
        fast_o   = (operando_a[M] == operando_b[M]) && (sum[M] != operando_a[M]);
      end
      C_SUB: begin
        fast_res = operando_a - operando_b;
        fast_c   = (operando_a < operando_b);
        fast_o   = (operando_a[M] != operando_b[M]) && (fast_res[M] != operando_a[M]);
      end
      C_MUL: go_mul = 1'b1;
      C_DIV: begin
        if (operando_b == '0) begin
          fast_res = '1;
          fast_err = 1'b1;
          fast_o   = 1'b1;
        end else begin
          go_div = 1'b1;
        end
      end
      C_REM: begin
        if (operando_b == '0) begin
          fast_res = operando_a;
          fast_err = 1'b1;
          fast_o   = 1'b1;
        end else begin
          go_div = 1'b1;
        end
      end
      default: begin
        fast_legal = 1'b0;
        fast_err   = 1'b1;
      end
    endcase
    // Divide by zero forces Z low; an illegal opcode reports no flags at all.
    fast_s = fast_legal && fast_res[M];
    fast_z = fast_legal && !fast_err && (fast_res == '0);
  end

  alu_muldiv_iter #(
    .BITS_DATA(BITS_DATA)
  ) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (go_div ? MODE_DIV : MODE_MUL),
    .a         (operando_a),
    .b         (operando_b),
    .done      (iter_done),
    .product_lo(product_lo),
    .product_hi(product_hi),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Select the finished multi-cycle result.
  always_comb begin
    iter_res    = quotient;
    iter_o      = 1'b0;
    iter_finish = iter_done && ((state_q == ST_MUL) || (state_q == ST_DIV));
    if (state_q == ST_MUL) begin
      iter_res = product_lo;
      iter_o   = |product_hi;
    end else if (op_q == C_REM) begin
      iter_res = remainder;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (go_mul)      state_d = ST_MUL;
          else if (go_div) state_d = ST_DIV;
          else             state_d = ST_DONE;
        end
      end
      ST_MUL:  if (iter_done) state_d = ST_DONE;
      ST_DIV:  if (iter_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Opcode latch so DIV and REM can be told apart when the iterator finishes.
  always_ff @(posedge clk) begin
    if (!rst_n)      op_q <= '0;
    else if (accept) op_q <= opcode;
  end

  // Result and flag registers: loaded on accept for single-cycle ops, or
  // when the iterator completes for MUL/DIV/REM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resultado <= '0;
      C         <= 1'b0;
      S         <= 1'b0;
      O         <= 1'b0;
      Z         <= 1'b0;
      err       <= 1'b0;
    end else if (accept && !start) begin
      resultado <= fast_res;
      C         <= fast_c;
      S         <= fast_s;
      O         <= fast_o;
      Z         <= fast_z;
      err       <= fast_err;
    end else if (iter_finish) begin
      resultado <= iter_res;
      C         <= 1'b0;
      S         <= iter_res[M];
      O         <= iter_o;
      Z         <= (iter_res == '0);
      err       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed test of alu_secuencial at BITS_DATA=32: arithmetic results,
// flags, latencies, back-pressure, illegal opcodes and mid-op reset.
module tb_alu_secuencial;
  import alu_secuencial_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operando_a;
  logic [W-1:0] operando_b;
  logic [4:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] resultado;
  logic         C, S, O, Z, err;
  state_t       fsm_state;

  int checks = 0;
  int errors = 0;
  int lat;
  int seen;

  alu_secuencial #(
    .BITS_DATA  (W),
    .BITS_OPCODE(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operando_a(operando_a),
    .operando_b(operando_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .resultado (resultado),
    .C         (C),
    .S         (S),
    .O         (O),
    .Z         (Z),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation, let it be accepted, then count cycles to out_valid
  // (1 = visible right after the accepting edge).
  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int l);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid   = 1'b1;
    opcode     = op;
    operando_a = a;
    operando_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    l = 1;
    while (out_valid !== 1'b1 && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  // Compare latency, result and flags {C,S,O,Z,err}.
  task automatic expect_res(input string tag, input int l, input int exp_l,
                            input logic [W-1:0] exp_r, input logic [4:0] exp_f);
    check({tag, "_latency"}, 64'(l), 64'(exp_l));
    check({tag, "_resultado"}, resultado, exp_r);
    check({tag, "_flags_CSOZE"}, {C, S, O, Z, err}, exp_f);
  endtask

  // Accept the result and confirm exactly one transfer.
  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_out_valid_after_take"}, out_valid, 1'b0);
    check({tag, "_in_ready_after_take"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    operando_a = '0;
    operando_b = '0;
    opcode     = '0;
    out_ready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_resultado", resultado, 32'h0);
    check("rst_flags", {C, S, O, Z, err}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD overflow into sign bit
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1, lat);
    expect_res("add_ovf", lat, 1, 32'h8000_0000, 5'b01100);
    consume("add_ovf");

    // ADD with carry out
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat);
    expect_res("add_carry", lat, 1, 32'h0, 5'b10010);
    consume("add_carry");

    // SUB with borrow
    send(OP_SUB, 32'h0, 32'h1, lat);
    expect_res("sub_borrow", lat, 1, 32'hFFFF_FFFF, 5'b11000);
    consume("sub_borrow");

    // SUB to zero
    send(OP_SUB, 32'h5, 32'h5, lat);
    expect_res("sub_zero", lat, 1, 32'h0, 5'b00010);
    consume("sub_zero");

    // SUB signed overflow: 0x80000000 - 1
    send(OP_SUB, 32'h8000_0000, 32'h1, lat);
    expect_res("sub_ovf", lat, 1, 32'h7FFF_FFFF, 5'b00100);
    consume("sub_ovf");

    // Logic ops and negate
    send(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, lat);
    expect_res("and", lat, 1, 32'h0000_00F0, 5'b00000);
    consume("and");
    send(OP_OR, 32'hF000_0000, 32'h0000_000F, lat);
    expect_res("or", lat, 1, 32'hF000_000F, 5'b01000);
    consume("or");
    send(OP_NOT, 32'h0, 32'h1234, lat);
    expect_res("not", lat, 1, 32'hFFFF_FFFF, 5'b01000);
    consume("not");
    send(OP_NEG, 32'h1, 32'h0, lat);
    expect_res("neg", lat, 1, 32'hFFFF_FFFF, 5'b01000);
    consume("neg");

    // MUL with high half set
    send(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat);
    expect_res("mul_hi", lat, 33, 32'h0, 5'b00110);
    consume("mul_hi");

    // MUL small
    send(OP_MUL, 32'd7, 32'd6, lat);
    expect_res("mul_small", lat, 33, 32'd42, 5'b00000);
    consume("mul_small");

    // MUL large: 0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE_00000001
    send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    expect_res("mul_max", lat, 33, 32'h0000_0001, 5'b00100);
    consume("mul_max");

    // DIV and REM
    send(OP_DIV, 32'd100, 32'd7, lat);
    expect_res("div", lat, 33, 32'd14, 5'b00000);
    consume("div");
    send(OP_REM, 32'd100, 32'd7, lat);
    expect_res("rem", lat, 33, 32'd2, 5'b00000);
    consume("rem");
    send(OP_DIV, 32'hFFFF_FFFF, 32'h1, lat);
    expect_res("div_max", lat, 33, 32'hFFFF_FFFF, 5'b01000);
    consume("div_max");
    send(OP_REM, 32'd6, 32'd3, lat);
    expect_res("rem_zero", lat, 33, 32'd0, 5'b00010);
    consume("rem_zero");

    // Divide by zero
    send(OP_DIV, 32'd9, 32'd0, lat);
    expect_res("div0", lat, 1, 32'hFFFF_FFFF, 5'b01101);
    consume("div0");
    send(OP_REM, 32'd9, 32'd0, lat);
    expect_res("rem0", lat, 1, 32'd9, 5'b00101);
    consume("rem0");

    // Illegal opcode
    send(5'h1F, 32'h1234, 32'h5678, lat);
    expect_res("illegal", lat, 1, 32'h0, 5'b00001);
    consume("illegal");

    // Back-pressure: result held, new in_valid ignored
    @(negedge clk);
    out_ready = 1'b0;
    send(OP_ADD, 32'd2, 32'd3, lat);
    expect_res("hold", lat, 1, 32'd5, 5'b00000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      opcode     = OP_SUB;
      operando_a = 32'd100 + 32'(i);
      operando_b = 32'd1;
      @(posedge clk);
      #1;
      check("hold_resultado", resultado, 32'd5);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_flags", {C, S, O, Z, err}, 5'b00000);
    consume("hold");
    check("hold_state_idle", fsm_state, ST_IDLE);
    send(OP_SUB, 32'd10, 32'd3, lat);
    expect_res("after_hold", lat, 1, 32'd7, 5'b00000);
    consume("after_hold");

    // Reset at cycle 10 of a MUL
    @(negedge clk);
    in_valid   = 1'b1;
    opcode     = OP_MUL;
    operando_a = 32'd1234;
    operando_b = 32'd5678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mulrst_busy", fsm_state, ST_MUL);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mulrst_state", fsm_state, ST_IDLE);
    check("mulrst_out_valid", out_valid, 1'b0);
    check("mulrst_in_ready", in_ready, 1'b1);
    check("mulrst_resultado", resultado, 32'h0);
    check("mulrst_flags", {C, S, O, Z, err}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("mulrst_no_result", 64'(seen), 64'd0);

    // Block still works after the abort
    send(OP_MUL, 32'd3, 32'd5, lat);
    expect_res("mul_after_rst", lat, 33, 32'd15, 5'b00000);
    consume("mul_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
